// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the fetch queue: reset PC, exception codes and packed entry-field offsets.
// Offsets are functions of FETCH_WIDTH/ECODE_W so the decode queue can reuse the same layout.
package if_fetch_queue_pkg;

   localparam logic [31:0] PC_RESET = 32'h1c00_0000;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_TLBR = 6'h3f;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cntOp_t;

   // Entry layout, LSB first: pc | pc_next | inst[FW] | mask | excp | ecode
   function automatic int entryOffPc();
      return 0;
   endfunction

   function automatic int entryOffPcNext();
      return 32;
   endfunction

   function automatic int entryOffInst();
      return 64;
   endfunction

   function automatic int entryOffMask(int fw);
      return 64 + 32 * fw;
   endfunction

   function automatic int entryOffExcp(int fw);
      return 64 + 33 * fw;
   endfunction

   function automatic int entryOffEcode(int fw);
      return 65 + 33 * fw;
   endfunction

   function automatic int entryWidth(int fw, int ew);
      return 65 + 33 * fw + ew;
   endfunction

endpackage

// File: rtl/if_fetch_queue_ram.sv
// DEPTH x WIDTH register array with one write port, one asynchronous read port and
// synchronous reset of every slot to RESET_VAL.
module if_fetch_queue_ram #(
   parameter int               DEPTH     = 4,
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wrEn,
   input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
   input  logic [WIDTH-1:0]         i_wrData,
   input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
   output logic [WIDTH-1:0]         o_rdData
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_VAL;
         end
      end else if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/if_fetch_queue.sv
// IF1 -> decode decoupling FIFO of fetch groups with flush, exception tag and empty-group squash.
// Define IF_FETCH_QUEUE_BYPASS_EN for a zero-latency path from in_* to out_* when the queue is empty.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int FETCH_WIDTH = 2,
   parameter int ECODE_W     = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_pc,
   input  logic [31:0]                  in_pc_next,
   input  logic [32*FETCH_WIDTH-1:0]    in_inst,
   input  logic [FETCH_WIDTH-1:0]       in_mask,
   input  logic                         in_excp,
   input  logic [ECODE_W-1:0]           in_ecode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_pc,
   output logic [31:0]                  out_pc_next,
   output logic [32*FETCH_WIDTH-1:0]    out_inst,
   output logic [FETCH_WIDTH-1:0]       out_mask,
   output logic                         out_excp,
   output logic [ECODE_W-1:0]           out_ecode,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW        = $clog2(DEPTH + 1);
   localparam int PW        = $clog2(DEPTH);
   localparam int EW        = entryWidth(FETCH_WIDTH, ECODE_W);
   localparam int OFF_PC    = entryOffPc();
   localparam int OFF_PCN   = entryOffPcNext();
   localparam int OFF_INST  = entryOffInst();
   localparam int OFF_MASK  = entryOffMask(FETCH_WIDTH);
   localparam int OFF_EXCP  = entryOffExcp(FETCH_WIDTH);
   localparam int OFF_ECODE = entryOffEcode(FETCH_WIDTH);

   localparam logic [EW-1:0] SLOT_RESET = {
      {ECODE_W{1'b0}},
      1'b0,
      {FETCH_WIDTH{1'b0}},
      {32*FETCH_WIDTH{1'b0}},
      PC_RESET + 32'(4 * FETCH_WIDTH),
      PC_RESET
   };

   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;

   logic          w_empty;
   logic          w_full;
   logic          w_squash;
   logic          w_bypass;
   logic          w_store;
   logic          w_popStore;
   cntOp_t        w_cntOp;
   logic [EW-1:0] w_wrData;
   logic [EW-1:0] w_rdData;
   logic          w_headExcp;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_squash = (in_mask == '0) & ~in_excp;

   assign in_ready = ~w_full & ~flush;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
   assign w_bypass = w_empty & in_valid & ~w_squash & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed group that is consumed the same cycle never touches storage
   assign w_store    = in_valid & in_ready & ~w_squash & ~(w_bypass & out_ready);
   assign w_popStore = ~w_empty & ~flush & out_ready;

   assign w_wrData = {in_ecode, in_excp, in_mask, in_inst, in_pc_next, in_pc};

   always_comb begin
      w_cntOp = CNT_HOLD;
      if (w_store && !w_popStore) begin
         w_cntOp = CNT_INC;
      end else if (!w_store && w_popStore) begin
         w_cntOp = CNT_DEC;
      end
   end

   // Flush only rewinds control state; slot payloads stay as they were
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_store) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_popStore) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case (w_cntOp)
            CNT_INC: r_count <= r_count + CW'(1);
            CNT_DEC: r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   if_fetch_queue_ram #(
      .DEPTH    (DEPTH),
      .WIDTH    (EW),
      .RESET_VAL(SLOT_RESET)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_wrEn  (w_store),
      .i_wrAddr(r_wrPtr),
      .i_wrData(w_wrData),
      .i_rdAddr(r_rdPtr),
      .o_rdData(w_rdData)
   );

   assign count      = r_count;
   assign out_valid  = w_bypass | (~w_empty & ~flush);
   assign w_headExcp = w_bypass ? in_excp : w_rdData[OFF_EXCP];

   assign out_pc      = w_bypass ? in_pc      : w_rdData[OFF_PC +: 32];
   assign out_pc_next = w_bypass ? in_pc_next : w_rdData[OFF_PCN +: 32];
   assign out_inst    = w_bypass ? in_inst    : w_rdData[OFF_INST +: 32*FETCH_WIDTH];
   assign out_excp    = w_headExcp;
   assign out_ecode   = w_bypass ? in_ecode   : w_rdData[OFF_ECODE +: ECODE_W];

   // An excepting group presents only slot 0 so decode raises the fault exactly once
   assign out_mask = w_headExcp ? FETCH_WIDTH'(1)
                   : (w_bypass ? in_mask : w_rdData[OFF_MASK +: FETCH_WIDTH]);

endmodule
